// File: rtl/disp_scan_ctrl_if.sv
// Display scan bus: scan controls in, digit select and anode drive out.
// The master modport belongs to the block that owns the controls (the
// bench, or upstream calculator logic). The slave modport belongs to the
// scan controller.
interface disp_scan_ctrl_if;
  logic       en;
  logic [3:0] digit_mask;
  logic [3:0] sel;
  logic [3:0] an_n;
  logic [1:0] digit_idx;
  logic       frame_start;

  modport master (
    output en,
    output digit_mask,
    input  sel,
    input  an_n,
    input  digit_idx,
    input  frame_start
  );

  modport slave (
    input  en,
    input  digit_mask,
    output sel,
    output an_n,
    output digit_idx,
    output frame_start
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Display scan controller.
// - Splits clk into slots of DIV_MAX+1 cycles.
// - Steps a one-hot digit select through the unmasked digits, one digit per slot.
// - Keeps the anodes dark for BLANK_CYC cycles at the start of each slot so the
//   byte mux can settle before its digit is shown.
// - Pulses frame_start whenever the scan wraps back to the lowest digit.
module disp_scan_ctrl #(
  parameter int DIV_W     = 16,
  parameter int DIV_MAX   = 49999,
  parameter int BLANK_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  disp_scan_ctrl_if.slave      bus
);

  localparam logic [DIV_W-1:0] DIV_MAX_C = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] BLANK_C   = DIV_W'(BLANK_CYC);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Index of the lowest set bit; zero for an empty mask.
  function automatic logic [1:0] lowest_set(input logic [3:0] mask);
    logic [1:0] idx;
    casez (mask)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Next enabled digit after cur in circular order.
  // Returns cur itself if cur is the only enabled digit.
  function automatic logic [1:0] next_digit(input logic [1:0] cur, input logic [3:0] mask);
    logic [3:0] above;
    case (cur)
      2'd0:    above = mask & 4'b1110;
      2'd1:    above = mask & 4'b1100;
      2'd2:    above = mask & 4'b1000;
      2'd3:    above = 4'b0000;
      default: above = 4'b0000;
    endcase
    if (above != 4'b0000) begin
      return lowest_set(above);
    end else begin
      return lowest_set(mask);
    end
  endfunction

  state_t           state_r, state_s;
  logic [DIV_W-1:0] presc_r, presc_s;
  logic [DIV_W-1:0] blank_r, blank_s;
  logic [3:0]       sel_r, sel_s;
  logic [3:0]       an_n_r, an_n_s;
  logic [1:0]       idx_r, idx_s;
  logic             fs_r, fs_s;
  logic             tick_s;
  logic             load_s;
  logic [1:0]       nxt_s;

  // Prescaler: free-runs while enabled; tick marks the last cycle of a slot.
  always_comb begin
    tick_s  = bus.en && (presc_r == DIV_MAX_C);
    presc_s = presc_r;
    if (!bus.en) begin
      presc_s = presc_r;
    end else if (presc_r == DIV_MAX_C) begin
      presc_s = {DIV_W{1'b0}};
    end else begin
      presc_s = presc_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  // Scan FSM next state, plus the digit load and frame-start decisions.
  // An empty mask drops back to IDLE even while scanning is paused.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    fs_s    = 1'b0;
    load_s  = 1'b0;
    nxt_s   = next_digit(idx_r, bus.digit_mask);
    case (state_r)
      ST_IDLE: begin
        if (tick_s && (bus.digit_mask != 4'b0000)) begin
          state_s = ST_SCAN;
          idx_s   = lowest_set(bus.digit_mask);
          fs_s    = 1'b1;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (bus.digit_mask == 4'b0000) begin
          state_s = ST_IDLE;
        end else if (tick_s) begin
          state_s = ST_SCAN;
          idx_s   = nxt_s;
          fs_s    = (nxt_s <= idx_r);
          load_s  = 1'b1;
        end else begin
          state_s = ST_SCAN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Blanking counter and output decode, both computed from next-state values.
  // A digit's anode lights only once the blanking interval has expired, and
  // only while scanning is enabled and that digit is still unmasked.
  always_comb begin
    blank_s = blank_r;
    if (load_s) begin
      blank_s = {DIV_W{1'b0}};
    end else if (bus.en && (blank_r < BLANK_C)) begin
      blank_s = blank_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end else begin
      blank_s = blank_r;
    end

    sel_s = 4'b0000;
    if (state_s == ST_SCAN) begin
      sel_s = 4'b0001 << idx_s;
    end else begin
      sel_s = 4'b0000;
    end

    an_n_s = 4'b1111;
    if (bus.en && (blank_s >= BLANK_C)) begin
      an_n_s = ~(sel_s & bus.digit_mask);
    end else begin
      an_n_s = 4'b1111;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      presc_r <= {DIV_W{1'b0}};
      blank_r <= {DIV_W{1'b0}};
      sel_r   <= 4'b0000;
      an_n_r  <= 4'b1111;
      idx_r   <= 2'd0;
      fs_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      presc_r <= presc_s;
      blank_r <= blank_s;
      sel_r   <= sel_s;
      an_n_r  <= an_n_s;
      idx_r   <= idx_s;
      fs_r    <= fs_s;
    end
  end

  assign bus.sel         = sel_r;
  assign bus.an_n        = an_n_r;
  assign bus.digit_idx   = idx_r;
  assign bus.frame_start = fs_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl.
// - Drives directed scan scenarios first, then a randomized run.
// - Checks every cycle against a slot-level behavioural model of the display scan.
module tb_disp_scan_ctrl;

  localparam int DIV_MAX = 3;
  localparam int BLANK   = 1;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  disp_scan_ctrl_if bus ();

  disp_scan_ctrl #(
    .DIV_W     (16),
    .DIV_MAX   (DIV_MAX),
    .BLANK_CYC (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  int         m_presc;
  int         m_blank;
  int         m_idx;
  bit         m_active;
  logic [3:0] m_sel;
  logic [3:0] m_an;
  logic       m_fs;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, given the inputs seen at that edge.
  task automatic model_edge(input logic en_v, input logic [3:0] mask_v, input logic rst_v);
    int nxt;
    bit load;
    bit tick;
    if (!rst_v) begin
      m_presc  = 0;
      m_blank  = 0;
      m_idx    = 0;
      m_active = 0;
      m_sel    = 4'b0000;
      m_an     = 4'b1111;
      m_fs     = 1'b0;
    end else begin
      tick = en_v && (m_presc == DIV_MAX);
      load = 0;
      m_fs = 1'b0;
      nxt  = m_idx;
      if (m_active && (mask_v == 4'b0000)) begin
        m_active = 0;
      end else if (tick && (mask_v != 4'b0000)) begin
        nxt = -1;
        if (m_active) begin
          for (int k = m_idx + 1; k < 4; k++) if (mask_v[k] && nxt < 0) nxt = k;
        end
        for (int k = 0; k < 4; k++) if (mask_v[k] && nxt < 0) nxt = k;
        m_fs     = !m_active || (nxt <= m_idx);
        m_active = 1;
        load     = 1;
      end
      if (load) begin
        m_idx   = nxt;
        m_blank = 0;
      end else if (en_v && m_blank < BLANK) begin
        m_blank++;
      end
      if (en_v) m_presc = (m_presc == DIV_MAX) ? 0 : m_presc + 1;
      m_sel = m_active ? (4'b0001 << m_idx) : 4'b0000;
      m_an  = 4'b1111;
      if (m_active && en_v && mask_v[m_idx] && m_blank >= BLANK) m_an[m_idx] = 1'b0;
    end
  endtask

  // Apply inputs for one cycle, then check the DUT against the model and the invariants.
  task automatic step(input logic en_v, input logic [3:0] mask_v, input logic rst_v);
    bus.en         = en_v;
    bus.digit_mask = mask_v;
    rst_n          = rst_v;
    @(posedge clk);
    model_edge(en_v, mask_v, rst_v);
    #1;
    check("sel", {4'b0000, bus.sel}, {4'b0000, m_sel});
    check("an_n", {4'b0000, bus.an_n}, {4'b0000, m_an});
    check("digit_idx", {6'b000000, bus.digit_idx}, 8'(m_idx));
    check("frame_start", {7'b0000000, bus.frame_start}, {7'b0000000, m_fs});
    check("sel_onehot0", {7'b0000000, $onehot0(bus.sel)}, 8'd1);
    check("an_onehot0", {7'b0000000, $onehot0(~bus.an_n)}, 8'd1);
    if (bus.sel != 4'b0000) check("idx_match", {4'b0000, bus.sel}, {4'b0000, 4'b0001 << bus.digit_idx});
  endtask

  bit found;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_presc  = 0;
    m_blank  = 0;
    m_idx    = 0;
    m_active = 0;
    m_sel    = 4'b0000;
    m_an     = 4'b1111;
    m_fs     = 1'b0;

    // Reset values.
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    check("rst_sel", {4'b0000, bus.sel}, 8'h00);
    check("rst_an", {4'b0000, bus.an_n}, 8'h0F);

    // Full scan of all four digits.
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 4'b1111, 1'b1);
      if (i == 3) check("pre_tick_sel", {4'b0000, bus.sel}, 8'h00);
      if (i == 4) begin
        check("first_sel", {4'b0000, bus.sel}, 8'h01);
        check("first_fs", {7'b0000000, bus.frame_start}, 8'h01);
        check("first_blank", {4'b0000, bus.an_n}, 8'h0F);
      end
      if (i == 5) check("first_on", {4'b0000, bus.an_n}, 8'h0E);
      if (i == 8) check("second_sel", {4'b0000, bus.sel}, 8'h02);
    end

    // Sparse mask 1010: digits 0 and 2 never light.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'b1010, 1'b1);
      check("mask1010_dark", {6'b000000, bus.an_n[2], bus.an_n[0]}, 8'h03);
    end

    // Clear the mask while digit 2 is selected, then restore digit 0 alone.
    found = 0;
    for (int k = 0; k < 24 && !found; k++) begin
      step(1'b1, 4'b1111, 1'b1);
      if (bus.sel == 4'b0100) found = 1;
    end
    check("reach_0100", {7'b0000000, found}, 8'h01);
    step(1'b1, 4'b0000, 1'b1);
    check("mask0_sel", {4'b0000, bus.sel}, 8'h00);
    check("mask0_an", {4'b0000, bus.an_n}, 8'h0F);
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0001, 1'b1);

    // Pause mid-slot while digit 1 is lit, then resume.
    found = 0;
    for (int k = 0; k < 24 && !found; k++) begin
      step(1'b1, 4'b1111, 1'b1);
      if (bus.sel == 4'b0010 && bus.an_n == 4'b1101) found = 1;
    end
    check("reach_0010_on", {7'b0000000, found}, 8'h01);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 1'b1);
      check("pause_dark", {4'b0000, bus.an_n}, 8'h0F);
    end
    for (int i = 0; i < 10; i++) step(1'b1, 4'b1111, 1'b1);

    // Reset while digit 3 is selected; the scan restarts at digit 0.
    found = 0;
    for (int k = 0; k < 24 && !found; k++) begin
      step(1'b1, 4'b1111, 1'b1);
      if (bus.sel == 4'b1000) found = 1;
    end
    check("reach_1000", {7'b0000000, found}, 8'h01);
    step(1'b1, 4'b1111, 1'b0);
    check("midrst_sel", {4'b0000, bus.sel}, 8'h00);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 4'b1111, 1'b1);
      if (i == 4) check("restart_sel", {4'b0000, bus.sel}, 8'h01);
    end

    // Single digit: every slot is a new frame.
    for (int i = 0; i < 16; i++) step(1'b1, 4'b0100, 1'b1);

    // Randomized run covering en, mask and reset.
    begin
      logic [3:0] mask_v;
      logic       en_v;
      logic       rst_v;
      mask_v = 4'b1111;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 15) == 0) mask_v = 4'($urandom_range(0, 15));
        en_v  = ($urandom_range(0, 7) != 0);
        rst_v = ($urandom_range(0, 149) != 0);
        step(en_v, mask_v, rst_v);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Display scan controller. Feeds the one-hot 4-bit digit select that drives the calculator's 4:1 byte multiplexer, plus the matching active-low 7-segment anode lines.
- Divides the system clock into digit slots and rotates a one-hot select across enabled digits, skipping masked ones.
- Inserts an anode-blanking interval at the start of each slot to suppress ghosting while the mux output settles.
- Emits a frame-start pulse so upstream logic can update digit values between frames.

Parameters:
- DIV_W, 16, width of the prescaler counter.
- DIV_MAX, 49999, slot length minus 1 in clk cycles; a slot is DIV_MAX+1 cycles. Must fit in DIV_W bits.
- BLANK_CYC, 1000, anode-off cycles at the start of each slot. Legal range is 0..DIV_MAX.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- en, input, 1, scan enable.
- digit_mask, input, 4, 1 = digit i takes part in the scan.
- sel, output, 4, one-hot digit select to the mux; bit i = digit i; 0000 = none.
- an_n, output, 4, active-low anode drive.
- digit_idx, output, 2, binary index of the current digit.
- frame_start, output, 1, single-cycle pulse on entry into the lowest enabled digit.

Behaviour:
- Reset:
  - Synchronous, active-low, sampled on the clk edge.
  - On reset: state IDLE, prescaler=0, blank_cnt=0, sel=0000, an_n=1111, digit_idx=0, frame_start=0.
  - Reset mid-slot aborts the scan immediately.
- Registered outputs: all outputs are registered. an_n and sel update on the same edge.
- Prescaler:
  - Counts 0..DIV_MAX while en=1, then wraps to 0.
  - tick is asserted in the cycle where prescaler==DIV_MAX and en=1.
  - en=0: prescaler, blank_cnt, sel and digit_idx hold; an_n is forced to 1111 on the next edge.
- States:
  - IDLE (sel=0000): on tick, if digit_mask!=0, go to SCAN, load the lowest enabled digit and pulse frame_start. If digit_mask==0, stay in IDLE.
  - SCAN: on tick, advance to the next enabled digit in circular order 0→1→2→3→0.
    - Next digit = first index above the current one with its mask bit set; otherwise wrap to the lowest set bit.
    - frame_start pulses on the same edge sel loads a digit whose index ≤ the previous index (wrap), including the single-digit case.
  - SCAN with digit_mask==0 (sampled any cycle): next edge goes to IDLE, sel=0000, an_n=1111, digit_idx holds.
- Blanking:
  - blank_cnt is cleared on the edge that loads a new digit and increments while en=1, saturating at BLANK_CYC.
  - an_n[i]=0 only if sel[i]=1, digit_mask[i]=1, en=1 and blank_cnt≥BLANK_CYC, evaluated on next-state values.
  - So each slot shows BLANK_CYC cycles of 1111, then DIV_MAX+1−BLANK_CYC cycles with one anode low.
  - BLANK_CYC=0: no blanking.
- Mask changes:
  - If the current digit's mask bit clears mid-slot, its anode goes high on the next edge.
  - sel stays until the next tick, then skips that digit.
  - Newly set bits join at the next advance.
- Invariants:
  - sel is always one-hot or zero.
  - digit_idx matches sel whenever sel!=0.
  - At most one an_n bit is low.
- Simultaneous events: rst_n=0 overrides everything; en=0 overrides tick.

Test Plan:
- DIV_MAX=3, BLANK_CYC=1, mask=1111, en=1, release reset at cycle 0.
  - Tick at prescaler=3 → sel=0001, idx=0, frame_start=1 for 1 cycle.
  - an_n=1111 for 1 cycle, then 1110 for 3 cycles.
  - Then sel 0010, 0100, 1000, 0001, 4 cycles each; frame_start every 16 cycles.
- mask=1010 → sel sequence 0010, 1000, 0010…; an_n never drives bits 0/2 low; frame_start on each entry to 0010.
- mask=1111, reach sel=0100, then set mask=0000 → next edge sel=0000, an_n=1111. Restore mask=0001 → next tick sel=0001 with frame_start=1.
- en=0 for 5 cycles mid-slot (sel=0010, anode on) → an_n=1111, sel/prescaler frozen. After en=1, the slot resumes and the remaining cycle count is unchanged.
- rst_n=0 for 1 cycle while sel=1000 → next edge all outputs return to reset values; first tick restarts at sel=0001.
- mask=0100 only → sel held at 0100; frame_start pulses every DIV_MAX+1 cycles; an_n=1111 for BLANK_CYC cycles each slot, otherwise 1011.
